// File: rtl/dancing_segment_array.sv
// dancing_segment_array: a single lit segment chases around a multiplexed
// seven-segment display. It runs clockwise or counter-clockwise, or holds a
// static "g" bar in STOP mode. Three buttons pick the mode.
// Optional feature macro: DANCE_LAP_SPEEDUP_EN. When it is defined, the chase
// runs at double speed after its first lap, and dp marks the fast state.
module dancing_segment_array #(
  parameter int NDIG   = 4,
  parameter int DIV_W  = 26,
  parameter int SCAN_W = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            BNTL,
  input  logic            BNTR,
  input  logic            BNTC,
  output logic [6:0]      a_to_g,
  output logic [NDIG-1:0] an,
  output logic            dp,
  output logic [1:0]      mode,
  output logic            lap
);

  typedef enum logic [1:0] {
    MODE_CCW  = 2'd0,
    MODE_CW   = 2'd1,
    MODE_STOP = 2'd2
  } mode_e;

  // A one-digit build still needs a legal select width. The select value is
  // forced to zero in that case.
  localparam int SEL_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Button order in every vector below is {C, R, L}.
  logic [2:0] sync1, sync2, sync_d, edge_q;

  mode_e              mode_q, mode_d;
  logic [2:0]         frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SCAN_W-1:0]  scan_q;
  logic               lap_d;
  logic               step_hit;
`ifdef DANCE_LAP_SPEEDUP_EN
  logic               fast_q, fast_d;
`endif

  logic [SEL_W-1:0]   sel;
  logic [3:0]         pos_sum;
  logic [2:0]         pos;
  logic [6:0]         seg_d;
  logic [NDIG-1:0]    an_d;
  logic               dp_d;

  // Two-flop synchroniser, then a registered rising-edge detector. A held
  // button therefore produces exactly one accepted edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the value from before the edge, so the order of
    // statements does not matter.
    if (clr) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_d <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= {BNTC, BNTR, BNTL};
      sync2  <= sync1;
      sync_d <= sync2;
      edge_q <= sync2 & ~sync_d;
    end
  end

  // Next-state logic for mode, frame, divider and the fast flag.
  always_comb begin
    // NOTE: every output of this block gets a default first. If a default
    // were missing, an untaken branch would infer a latch.
    mode_d  = mode_q;
    frame_d = frame_q;
    div_d   = div_q + DIV_W'(1);
    lap_d   = 1'b0;
`ifdef DANCE_LAP_SPEEDUP_EN
    fast_d   = fast_q;
    step_hit = fast_q ? (&div_q[DIV_W-2:0]) : (&div_q);
`else
    step_hit = &div_q;
`endif

    if (|edge_q) begin
      // Any accepted edge restarts the animation, even when it reselects
      // the current mode.
      if (edge_q[2])      mode_d = MODE_STOP;
      else if (edge_q[1]) mode_d = MODE_CW;
      else                mode_d = MODE_CCW;
      frame_d = 3'd0;
      div_d   = '0;
`ifdef DANCE_LAP_SPEEDUP_EN
      fast_d  = 1'b0;
`endif
    end else if (step_hit) begin
      case (mode_q)
        MODE_CW: begin
          if (frame_q == 3'd5) begin
            frame_d = 3'd0;
            lap_d   = 1'b1;
          end else begin
            frame_d = frame_q + 3'd1;
          end
        end
        MODE_CCW: begin
          if (frame_q == 3'd0) begin
            frame_d = 3'd5;
            lap_d   = 1'b1;
          end else begin
            frame_d = frame_q - 3'd1;
          end
        end
        default: frame_d = frame_q;
      endcase
`ifdef DANCE_LAP_SPEEDUP_EN
      if (lap_d) fast_d = 1'b1;
`endif
    end
  end

  // Display decode: the active digit d shows segment (frame + d) mod 6.
  always_comb begin
    if (NDIG > 1) sel = scan_q[SCAN_W-1 -: SEL_W];
    else          sel = '0;

    pos_sum = 4'(frame_q) + 4'(sel);
    if (pos_sum >= 4'd6) pos_sum = pos_sum - 4'd6;
    if (pos_sum >= 4'd6) pos_sum = pos_sum - 4'd6;
    pos = pos_sum[2:0];

    if (mode_q == MODE_STOP) seg_d = 7'b0111111;
    else                     seg_d = ~(7'b0000001 << pos);

    if (NDIG > 1) an_d = ~(NDIG'(1) << sel);
    else          an_d = '0;

`ifdef DANCE_LAP_SPEEDUP_EN
    dp_d = ~fast_q;
`else
    dp_d = 1'b1;
`endif
  end

  // Animation state and the free-running scan counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      mode_q  <= MODE_STOP;
      frame_q <= 3'd0;
      div_q   <= '0;
      scan_q  <= '0;
`ifdef DANCE_LAP_SPEEDUP_EN
      fast_q  <= 1'b0;
`endif
    end else begin
      mode_q  <= mode_d;
      frame_q <= frame_d;
      div_q   <= div_d;
      scan_q  <= scan_q + SCAN_W'(1);
`ifdef DANCE_LAP_SPEEDUP_EN
      fast_q  <= fast_d;
`endif
    end
  end

  // Registered outputs. Segments and anodes load on the same edge, so
  // digits never ghost.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_to_g <= 7'b1111111;
      an     <= '1;
      dp     <= 1'b1;
      lap    <= 1'b0;
    end else begin
      a_to_g <= seg_d;
      an     <= an_d;
      dp     <= dp_d;
      lap    <= lap_d;
    end
  end

  assign mode = mode_q;

endmodule

// File: doc/dancing_segment_array.md
DANCING_SEGMENT_ARRAY -- requirements
Module: dancing_segment_array

Interface
REQ-001 Parameter NDIG, default 4: number of digits driven; legal values 1, 2, 4, 8.
REQ-002 Parameter DIV_W, default 26: step-divider width; one animation step per 2^DIV_W clocks (slow rate); legal range 2..31.
REQ-003 Parameter SCAN_W, default 16: digit-scan counter width; each digit active for 2^(SCAN_W-log2(NDIG)) clocks; SCAN_W > log2(NDIG).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 BNTL  input  1  button: select counter-clockwise chase (CCW).
REQ-007 BNTR  input  1  button: select clockwise chase (CW).
REQ-008 BNTC  input  1  button: select STOP (static) mode.
REQ-009 a_to_g  output  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
REQ-010 an  output  NDIG  digit anodes, active-low, one-hot while scanning.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 mode  output  2  current mode: 0 CCW, 1 CW, 2 STOP.
REQ-013 lap  output  1  one-clock pulse when the frame pointer wraps.

Function
REQ-014 Each button SHALL pass through a 2-flop synchroniser and a rising-edge detector; held buttons act once.
REQ-015 Button edge detected at clock edge N SHALL update mode at edge N+1; a button first sampled high at edge K updates mode at edge K+3.
REQ-016 Simultaneous edges SHALL resolve with priority BNTC > BNTR > BNTL.
REQ-017 Any accepted edge, including one that reselects the current mode, SHALL clear the step divider, set frame to 0 and clear the fast flag, on the same edge the mode updates.
REQ-018 Frame pointer SHALL be 3 bits, range 0..5; pattern P(0..5) = single lit segment a,b,c,d,e,f respectively.
REQ-019 On each divider terminal count: CW frame +1 with 5->0 wrap; CCW frame -1 with 0->5 wrap; STOP frame holds.
REQ-020 lap SHALL pulse for one clock on the step that performs a 5->0 wrap (CW) or 0->5 wrap (CCW); never in STOP.
REQ-021 Digit d SHALL show P((frame + d) mod 6) in CW and CCW, so the chase travels across digits; in STOP every digit shows segment g only (7'b0111111).
REQ-022 Scan counter SHALL free-run; active digit = top log2(NDIG) bits; an drives that bit low; for NDIG=1, an = 1'b0 constantly.
REQ-023 a_to_g, an, dp, lap SHALL be registered; a_to_g/an reflect frame and scan state one clock after they change; no digit ghosting (a_to_g and an change on the same edge).
REQ-024 dp SHALL be 1 (off) at all times unless DANCE_LAP_SPEEDUP_EN is defined (see REQ-029).
REQ-025 Divider SHALL wrap silently; no overflow beyond DIV_W bits.

Reset
REQ-026 clr high at an edge SHALL set: mode = STOP, frame = 0, divider = 0, scan = 0, fast flag = 0, sync/edge flops = 0, a_to_g = 7'b1111111, an = all ones, dp = 1, lap = 0.
REQ-027 clr SHALL override simultaneous button edges and steps; reset mid-animation discards all progress; first outputs valid one clock after clr falls.

Configuration
REQ-028 Macro DANCE_LAP_SPEEDUP_EN: when defined, after the first lap since the last mode change the fast flag sets and steps occur every 2^(DIV_W-1) clocks; fast flag clears per REQ-017/REQ-026.
REQ-029 With DANCE_LAP_SPEEDUP_EN defined, dp of the active digit SHALL be 0 while fast flag is set; without it, step rate is always 2^DIV_W clocks, no fast flag exists, dp = 1.

Verification (DIV_W=4, SCAN_W=4, NDIG=4)
REQ-030 clr 1 cycle, no buttons -> mode=2, all digits show 7'b0111111, an cycles 1110,1101,1011,0111 every 4 clocks, lap never pulses.
REQ-031 BNTR pulse -> mode=1 three edges later; frame steps 0..5 every 16 clocks; digit 0 shows 7'b1111110 at frame 0; lap pulses once at 5->0.
REQ-032 BNTL then BNTR asserted same cycle -> mode=1; BNTC+BNTR same cycle -> mode=2.
REQ-033 BNTL held 200 clocks -> exactly one mode change, frame counts 0,5,4,..., lap on 0->5.
REQ-034 With DANCE_LAP_SPEEDUP_EN: CW run -> step interval 16 clocks for first lap, 8 clocks after, dp=0 on active digit; pressing BNTR again -> interval back to 16, dp=1.
REQ-035 clr asserted mid-CW at frame 3 -> next cycle mode=2, frame=0, outputs all-off, then STOP pattern.
